// File: rtl/fabric_mem_rsp.sv
// fabric_mem_rsp: fabric-side memory responder for tile-level simulation and
// FPGA bring-up. It services WR/RD requests against a local byte memory and
// returns RD_RSP transactions after LAT cycles through a bounded response FIFO.
// Read credit covers both the delay line and the FIFO, so the FIFO cannot overflow.
// Optional statistics counters are enabled by defining FABRIC_MEM_RSP_STATS_EN.

package fabric_mem_rsp_pkg;
   typedef logic [7:0] t_tile_id;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_WR     = 3'd1;
   localparam logic [2:0] OP_RD     = 3'd2;
   localparam logic [2:0] OP_RD_RSP = 3'd3;

   typedef struct packed {
      logic [31:0] address;
      logic [2:0]  opcode;
      logic [31:0] data;
      logic [7:0]  requestor_id;
      logic [1:0]  next_tile_fifo_arb_id;
   } t_tile_trans;
endpackage

module fabric_mem_rsp
   import fabric_mem_rsp_pkg::*;
#(
   parameter int MEM_BYTES = 65536,
   parameter int LAT       = 3,
   parameter int RSP_DEPTH = 4
) (
   input  logic        Clock,
   input  logic        Rst,
   input  t_tile_id    local_tile_id,
   input  logic        InReqValid,
   input  t_tile_trans InReq,
   output logic        InReqReady,
   output logic        OutRspValid,
   output t_tile_trans OutRsp,
   input  logic        OutRspReady,
   output logic        BadOpcode,
   output logic [31:0] RdCnt,
   output logic [31:0] WrCnt,
   output logic [31:0] StallCnt
);
   localparam int AW = $clog2(MEM_BYTES);
   localparam int PW = $clog2(RSP_DEPTH);
   localparam int CW = $clog2(RSP_DEPTH) + 1;

   logic [7:0]    memBytes [MEM_BYTES];
   logic [AW-1:0] memIdx;
   logic [31:0]   rdWord;
   logic          accept, isWr, isRd, isBad;
   t_tile_trans   rspNew;
   logic          pushValid;
   t_tile_trans   pushTrans;
   logic          pop;

   t_tile_trans   fifoMem [RSP_DEPTH];
   logic [PW-1:0] rdPtr, wrPtr;
   logic [CW-1:0] fifoCnt;
   logic [CW-1:0] inFlight;

   // These request fields have no role in servicing a request.
   logic unusedBits;
   assign unusedBits = ^{InReq.address[31:24], InReq.requestor_id};

   assign memIdx = InReq.address[AW-1:0];
   assign isWr   = (InReq.opcode == OP_WR);
   assign isRd   = (InReq.opcode == OP_RD);
   assign isBad  = !isWr && !isRd;
   assign accept = InReqValid && InReqReady;
   assign pop    = OutRspValid && OutRspReady;

   // inFlight counts reads still in the delay line plus entries in the FIFO.
   assign InReqReady  = (inFlight < CW'(RSP_DEPTH));
   assign OutRspValid = (fifoCnt != '0);
   assign OutRsp      = OutRspValid ? fifoMem[rdPtr] : '0;

   // Byte memory write. The index wraps modulo MEM_BYTES and is not reset.
   always_ff @(posedge Clock) begin
      if (accept && isWr) begin
         for (int k = 0; k < 4; k++) begin
            memBytes[memIdx + AW'(k)] <= InReq.data[8*k +: 8];
         end
      end
   end

   // Read word assembled from current memory state with wrapping byte index.
   always_comb begin
      rdWord = '0;
      for (int k = 0; k < 4; k++) begin
         rdWord[8*k +: 8] = memBytes[memIdx + AW'(k)];
      end
   end

   // Response built from the request at the accept cycle.
   always_comb begin
      rspNew                       = '0;
      rspNew.address               = {local_tile_id, InReq.address[23:0]};
      rspNew.opcode                = OP_RD_RSP;
      rspNew.data                  = rdWord;
      rspNew.requestor_id          = InReq.address[7:0];
      rspNew.next_tile_fifo_arb_id = InReq.next_tile_fifo_arb_id;
   end

   // The FIFO push edge adds one cycle, so the delay line has LAT-1 registered stages.
   generate
      if (LAT == 1) begin : gNoDelay
         assign pushValid = accept && isRd;
         assign pushTrans = rspNew;
      end else begin : gDelay
         logic [LAT-2:0] stgValid;
         t_tile_trans    stgTrans [LAT-1];

         // Shift read responses toward the FIFO one stage per cycle.
         always_ff @(posedge Clock or posedge Rst) begin
            if (Rst) begin
               stgValid <= '0;
               for (int i = 0; i < LAT-1; i++) stgTrans[i] <= '0;
            end else begin
               stgValid[0] <= accept && isRd;
               stgTrans[0] <= rspNew;
               for (int i = 1; i < LAT-1; i++) begin
                  stgValid[i] <= stgValid[i-1];
                  stgTrans[i] <= stgTrans[i-1];
               end
            end
         end

         assign pushValid = stgValid[LAT-2];
         assign pushTrans = stgTrans[LAT-2];
      end
   endgenerate

   // FIFO storage. When the FIFO is full, a push with a pop overwrites the entry that is popped.
   always_ff @(posedge Clock) begin
      if (pushValid) fifoMem[wrPtr] <= pushTrans;
   end

   // FIFO pointers, occupancy and read credit tracking.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         rdPtr    <= '0;
         wrPtr    <= '0;
         fifoCnt  <= '0;
         inFlight <= '0;
      end else begin
         if (pushValid) wrPtr <= wrPtr + 1'b1;
         if (pop)       rdPtr <= rdPtr + 1'b1;
         fifoCnt  <= fifoCnt + CW'(pushValid) - CW'(pop);
         inFlight <= inFlight + CW'(accept && isRd) - CW'(pop);
      end
   end

   // One-cycle flag for an accepted request with an unsupported opcode.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) BadOpcode <= 1'b0;
      else     BadOpcode <= accept && isBad;
   end

`ifdef FABRIC_MEM_RSP_STATS_EN
   // Saturating traffic and stall counters.
   always_ff @(posedge Clock or posedge Rst) begin
      if (Rst) begin
         RdCnt    <= '0;
         WrCnt    <= '0;
         StallCnt <= '0;
      end else begin
         if (accept && isRd && (RdCnt != 32'hFFFF_FFFF))             RdCnt    <= RdCnt + 1'b1;
         if (accept && isWr && (WrCnt != 32'hFFFF_FFFF))             WrCnt    <= WrCnt + 1'b1;
         if (InReqValid && !InReqReady && (StallCnt != 32'hFFFF_FFFF)) StallCnt <= StallCnt + 1'b1;
      end
   end
`else
   assign RdCnt    = '0;
   assign WrCnt    = '0;
   assign StallCnt = '0;
`endif

endmodule

// File: tb/tb_fabric_mem_rsp.sv
// Testbench for fabric_mem_rsp. It runs directed vectors on a LAT=3 instance, plus
// backpressure, reset and latency-sweep sequences that use LAT=1 and LAT=8 instances.
module tb_fabric_mem_rsp;
   import fabric_mem_rsp_pkg::*;

   localparam int LAT = 3;

   logic        Clock = 1'b0;
   logic        Rst;
   t_tile_id    tileId;
   logic        InReqValid;
   t_tile_trans InReq;
   logic        OutRspReady;

   logic        rdyA, vldA, badA;
   t_tile_trans rspA;
   logic [31:0] rdCntA, wrCntA, stallCntA;
   logic        rdyB, vldB, unusedBadB;
   t_tile_trans rspB;
   logic [31:0] unusedRdB, unusedWrB, unusedStB;
   logic        rdyC, vldC, unusedBadC;
   t_tile_trans rspC;
   logic [31:0] unusedRdC, unusedWrC, unusedStC;

   int nTests = 0;
   int nFail  = 0;

   always #5 Clock = ~Clock;

   fabric_mem_rsp #(.MEM_BYTES(65536), .LAT(3), .RSP_DEPTH(4)) dut (
      .Clock(Clock), .Rst(Rst), .local_tile_id(tileId),
      .InReqValid(InReqValid), .InReq(InReq), .InReqReady(rdyA),
      .OutRspValid(vldA), .OutRsp(rspA), .OutRspReady(OutRspReady),
      .BadOpcode(badA), .RdCnt(rdCntA), .WrCnt(wrCntA), .StallCnt(stallCntA));

   fabric_mem_rsp #(.MEM_BYTES(65536), .LAT(1), .RSP_DEPTH(4)) dutLat1 (
      .Clock(Clock), .Rst(Rst), .local_tile_id(tileId),
      .InReqValid(InReqValid), .InReq(InReq), .InReqReady(rdyB),
      .OutRspValid(vldB), .OutRsp(rspB), .OutRspReady(OutRspReady),
      .BadOpcode(unusedBadB), .RdCnt(unusedRdB), .WrCnt(unusedWrB), .StallCnt(unusedStB));

   fabric_mem_rsp #(.MEM_BYTES(65536), .LAT(8), .RSP_DEPTH(16)) dutLat8 (
      .Clock(Clock), .Rst(Rst), .local_tile_id(tileId),
      .InReqValid(InReqValid), .InReq(InReq), .InReqReady(rdyC),
      .OutRspValid(vldC), .OutRsp(rspC), .OutRspReady(OutRspReady),
      .BadOpcode(unusedBadC), .RdCnt(unusedRdC), .WrCnt(unusedWrC), .StallCnt(unusedStC));

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  arb;
      logic        expRsp;
      logic        expBad;
      logic [31:0] expAddr;
      logic [31:0] expData;
      logic [7:0]  expReq;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic checkCnt(input string nm, input logic [31:0] act, input logic [31:0] expOn);
`ifdef FABRIC_MEM_RSP_STATS_EN
      check(nm, act, expOn);
`else
      check(nm, act, (expOn & 32'h0));
`endif
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] d, input logic [1:0] arb);
      InReqValid                  = v;
      InReq                       = '0;
      InReq.opcode                = op;
      InReq.address               = addr;
      InReq.data                  = d;
      InReq.requestor_id          = 8'h5A;
      InReq.next_tile_fifo_arb_id = arb;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   function automatic t_tile_trans mkRsp(input logic [31:0] addr, input logic [31:0] d,
                                         input logic [1:0] arb);
      t_tile_trans r;
      r                       = '0;
      r.address               = {8'h22, addr[23:0]};
      r.opcode                = OP_RD_RSP;
      r.data                  = d;
      r.requestor_id          = addr[7:0];
      r.next_tile_fifo_arb_id = arb;
      return r;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      t_tile_trans e;
      t_tile_trans sb [$];
      int rdExp, wrExp, accepted, stalls, got;

      vecs[0]  = '{OP_WR,     32'h2200_0010, 32'hDEAD_BEEF, 2'd0, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00};
      vecs[1]  = '{OP_RD,     32'h3300_0010, 32'h0,         2'd1, 1'b1, 1'b0, 32'h2200_0010, 32'hDEAD_BEEF, 8'h10};
      vecs[2]  = '{OP_WR,     32'h0000_0000, 32'hA5A5_0000, 2'd0, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00};
      vecs[3]  = '{OP_WR,     32'h0000_FFFE, 32'h4433_2211, 2'd0, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00};
      vecs[4]  = '{OP_RD,     32'h0000_FFFE, 32'h0,         2'd2, 1'b1, 1'b0, 32'h2200_FFFE, 32'h4433_2211, 8'hFE};
      vecs[5]  = '{OP_RD,     32'h0000_0000, 32'h0,         2'd3, 1'b1, 1'b0, 32'h2200_0000, 32'hA5A5_4433, 8'h00};
      vecs[6]  = '{OP_WR,     32'h5501_2344, 32'h0102_0304, 2'd0, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00};
      vecs[7]  = '{OP_RD,     32'h0000_2344, 32'h0,         2'd0, 1'b1, 1'b0, 32'h2200_2344, 32'h0102_0304, 8'h44};
      vecs[8]  = '{OP_WR,     32'h0000_0014, 32'h0000_00C3, 2'd0, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00};
      vecs[9]  = '{OP_RD,     32'h7712_0011, 32'h0,         2'd2, 1'b1, 1'b0, 32'h2212_0011, 32'hC3DE_ADBE, 8'h11};
      vecs[10] = '{OP_RD_RSP, 32'h0000_0010, 32'h1234_5678, 2'd0, 1'b0, 1'b1, 32'h0,         32'h0,         8'h00};
      vecs[11] = '{OP_NOP,    32'h0000_0010, 32'h0,         2'd1, 1'b0, 1'b1, 32'h0,         32'h0,         8'h00};
      vecs[12] = '{3'd7,      32'h0000_0010, 32'h0,         2'd2, 1'b0, 1'b1, 32'h0,         32'h0,         8'h00};

      tileId      = 8'h22;
      OutRspReady = 1'b1;
      drive(1'b0, OP_NOP, 32'h0, 32'h0, 2'd0);
      Rst = 1'b1;
      #12;
      check("rst_valid", vldA, 1'b0);
      check("rst_rsp", rspA, '0);
      check("rst_bad", badA, 1'b0);
      check("rst_rdcnt", rdCntA, 32'h0);
      repeat (2) @(negedge Clock);
      Rst = 1'b0;
      #1;
      check("rst_ready", rdyA, 1'b1);
      tick();

      rdExp = 0;
      wrExp = 0;
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].arb);
         @(negedge Clock);
         check($sformatf("vec%0d_ready", i), rdyA, 1'b1);
         tick();
         drive(1'b0, OP_NOP, 32'h0, 32'h0, 2'd0);
         if (vecs[i].op == OP_RD) rdExp++;
         if (vecs[i].op == OP_WR) wrExp++;
         e                       = '0;
         e.address               = vecs[i].expAddr;
         e.opcode                = OP_RD_RSP;
         e.data                  = vecs[i].expData;
         e.requestor_id          = vecs[i].expReq;
         e.next_tile_fifo_arb_id = vecs[i].arb;
         for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge Clock);
            check($sformatf("vec%0d_bad_c%0d", i, c), badA, (c == 1) && vecs[i].expBad);
            if (c == LAT) begin
               check($sformatf("vec%0d_valid", i), vldA, vecs[i].expRsp);
               if (vecs[i].expRsp) check($sformatf("vec%0d_rsp", i), rspA, e);
            end else begin
               check($sformatf("vec%0d_idle_c%0d", i, c), vldA, 1'b0);
            end
            tick();
         end
      end
      checkCnt("tbl_rdcnt", rdCntA, rdExp);
      checkCnt("tbl_wrcnt", wrCntA, wrExp);
      checkCnt("tbl_stallcnt", stallCntA, 32'd0);

      // Preload words for backpressure and latency sweep.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, OP_WR, 32'h400 + 32'(4*i), 32'hB0B0_0000 + 32'(i), 2'd0);
         tick();
         wrExp++;
      end
      drive(1'b0, OP_NOP, 32'h0, 32'h0, 2'd0);

      // Backpressure: the consumer is stalled while 8 reads are offered.
      OutRspReady = 1'b0;
      accepted = 0;
      stalls   = 0;
      got      = 0;
      for (int c = 0; c < 8; c++) begin
         drive(1'b1, OP_RD, 32'h400 + 32'(4*accepted), 32'h0, 2'(accepted));
         @(negedge Clock);
         if (c >= 4) check($sformatf("bp_ready_low_c%0d", c), rdyA, 1'b0);
         if (rdyA) begin
            sb.push_back(mkRsp(32'h400 + 32'(4*accepted), 32'hB0B0_0000 + 32'(accepted), 2'(accepted)));
            accepted++;
         end else begin
            stalls++;
         end
         tick();
      end
      check("bp_accepted4", accepted, 4);
      @(negedge Clock);
      check("bp_hold_valid", vldA, 1'b1);
      check("bp_hold_rsp", rspA, sb[0]);
      stalls++;
      tick();
      OutRspReady = 1'b1;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if (accepted < 8) drive(1'b1, OP_RD, 32'h400 + 32'(4*accepted), 32'h0, 2'(accepted));
         else              drive(1'b0, OP_NOP, 32'h0, 32'h0, 2'd0);
         @(negedge Clock);
         if (vldA) begin
            if (sb.size() == 0) begin
               check("bp_unexpected_rsp", vldA, 1'b0);
            end else begin
               check($sformatf("bp_rsp%0d", got), rspA, sb.pop_front());
            end
            got++;
         end
         if (InReqValid) begin
            if (rdyA) begin
               sb.push_back(mkRsp(32'h400 + 32'(4*accepted), 32'hB0B0_0000 + 32'(accepted), 2'(accepted)));
               accepted++;
            end else begin
               stalls++;
            end
         end
         tick();
      end
      drive(1'b0, OP_NOP, 32'h0, 32'h0, 2'd0);
      check("bp_got8", got, 8);
      check("bp_accepted8", accepted, 8);
      checkCnt("bp_stallcnt", stallCntA, stalls);
      checkCnt("bp_rdcnt", rdCntA, rdExp + 8);

      // Reset with three reads in flight.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, OP_RD, 32'h400 + 32'(4*i), 32'h0, 2'd0);
         tick();
      end
      drive(1'b0, OP_NOP, 32'h0, 32'h0, 2'd0);
      @(negedge Clock);
      check("rst_pre_valid", vldA, 1'b1);
      #2 Rst = 1'b1;
      #1;
      check("rst_mid_valid", vldA, 1'b0);
      check("rst_mid_rsp", rspA, '0);
      check("rst_mid_bad", badA, 1'b0);
      @(negedge Clock);
      Rst = 1'b0;
      tick();
      for (int c = 0; c < 10; c++) begin
         @(negedge Clock);
         check($sformatf("rst_no_stale_c%0d", c), vldA, 1'b0);
         tick();
      end
      checkCnt("rst_rdcnt_zero", rdCntA, 32'd0);
      drive(1'b1, OP_RD, 32'h3300_0010, 32'h0, 2'd1);
      tick();
      drive(1'b0, OP_NOP, 32'h0, 32'h0, 2'd0);
      for (int c = 1; c <= LAT; c++) begin
         @(negedge Clock);
         if (c == LAT) begin
            check("rst_wr_kept_valid", vldA, 1'b1);
            check("rst_wr_kept_rsp", rspA, mkRsp(32'h3300_0010, 32'hDEAD_BEEF, 2'd1));
         end
         tick();
      end
      checkCnt("rst_rdcnt_one", rdCntA, 32'd1);
      checkCnt("rst_wrcnt_zero", wrCntA, 32'd0);

      // Latency sweep: 8 back-to-back reads on LAT 1, 3 and 8 instances.
      Rst = 1'b1;
      @(negedge Clock);
      Rst = 1'b0;
      tick();
      for (int cyc = 0; cyc < 18; cyc++) begin
         if (cyc < 8) drive(1'b1, OP_RD, 32'h400 + 32'(4*cyc), 32'h0, 2'(cyc));
         else         drive(1'b0, OP_NOP, 32'h0, 32'h0, 2'd0);
         @(negedge Clock);
         if (cyc < 8) begin
            check($sformatf("sw_rdy1_c%0d", cyc), rdyB, 1'b1);
            check($sformatf("sw_rdy3_c%0d", cyc), rdyA, 1'b1);
            check($sformatf("sw_rdy8_c%0d", cyc), rdyC, 1'b1);
         end
         check($sformatf("sw_vld1_c%0d", cyc), vldB, (cyc >= 1) && (cyc < 9));
         check($sformatf("sw_vld3_c%0d", cyc), vldA, (cyc >= 3) && (cyc < 11));
         check($sformatf("sw_vld8_c%0d", cyc), vldC, (cyc >= 8) && (cyc < 16));
         if (cyc >= 1 && cyc < 9)
            check($sformatf("sw_rsp1_c%0d", cyc), rspB,
                  mkRsp(32'h400 + 32'(4*(cyc-1)), 32'hB0B0_0000 + 32'(cyc-1), 2'(cyc-1)));
         if (cyc >= 3 && cyc < 11)
            check($sformatf("sw_rsp3_c%0d", cyc), rspA,
                  mkRsp(32'h400 + 32'(4*(cyc-3)), 32'hB0B0_0000 + 32'(cyc-3), 2'(cyc-3)));
         if (cyc >= 8 && cyc < 16)
            check($sformatf("sw_rsp8_c%0d", cyc), rspC,
                  mkRsp(32'h400 + 32'(4*(cyc-8)), 32'hB0B0_0000 + 32'(cyc-8), 2'(cyc-8)));
         tick();
      end
      checkCnt("sw_rdcnt", rdCntA, 32'd8);
      checkCnt("sw_stallcnt", stallCntA, 32'd0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
